// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and constants for the truth-table sweeper and its comparator.
package tt_pkg;

    localparam int unsigned TT_N_IN  = 3;
    localparam int unsigned TT_R     = 2**TT_N_IN;
    localparam int unsigned TT_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_CHECK
    } tt_state_e;

    // Lab expected masks, bit r = Y for row {A,B,C} = r.
    // Table 1: majority of A,B,C.  Table 2: odd parity of A,B,C.
    localparam logic [TT_R-1:0] TT_TABLE1 = 8'hE8;
    localparam logic [TT_R-1:0] TT_TABLE2 = 8'h96;

    // Low bit of DUT d's table in a flattened bus; the slice is `rows` bits wide.
    function automatic int unsigned table_slice(input int unsigned d, input int unsigned rows);
        return d * rows;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_compare.sv
// Per-DUT table comparator: XOR captured against expected, OR-reduce each slice.
module tt_compare
    import tt_pkg::*;
#(
    parameter int unsigned N_IN  = TT_N_IN,
    parameter int unsigned N_DUT = 6
) (
    input  logic [N_DUT*(2**N_IN)-1:0] i_captured,
    input  logic [N_DUT*(2**N_IN)-1:0] i_expected,
    output logic [N_DUT-1:0]           o_mismatch
);

    localparam int unsigned R = 2**N_IN;

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        localparam int unsigned LO = table_slice(g, R);
        assign o_mismatch[g] = |(i_captured[LO +: R] ^ i_expected[LO +: R]);
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Clocked sweep of all input rows onto a shared DUT bus, capturing each DUT's
// truth table and comparing it against a mask latched at start.
module truth_table_sweeper
    import tt_pkg::*;
#(
    parameter int unsigned N_IN   = TT_N_IN,
    parameter int unsigned N_DUT  = 6,
    parameter int unsigned SETTLE = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [N_DUT*(2**N_IN)-1:0] expected,
    output logic [N_IN-1:0]            dut_in,
    input  logic [N_DUT-1:0]           dut_out,
    output logic                       busy,
    output logic                       done,
    output logic [N_DUT*(2**N_IN)-1:0] captured,
    output logic [N_DUT-1:0]           mismatch,
    output logic                       pass
);

    localparam int unsigned R = 2**N_IN;
    localparam int unsigned W = N_DUT * R;
    localparam logic [N_IN-1:0]     ROW_LAST = '1;
    localparam logic [TT_CNT_W-1:0] CNT_LAST = TT_CNT_W'(SETTLE - 1);

    tt_state_e             r_state;
    tt_state_e             w_state_nxt;
    logic [N_IN-1:0]       r_row;
    logic [TT_CNT_W-1:0]   r_cnt;
    logic [W-1:0]          r_exp;
    logic [N_IN-1:0]       r_dut_in;
    logic                  r_busy;
    logic                  r_done;
    logic [W-1:0]          r_captured;
    logic [N_DUT-1:0]      r_mismatch;
    logic                  r_pass;

    logic                  w_accept;
    logic                  w_cnt_inc;
    logic                  w_sample;
    logic                  w_check;
    logic [R-1:0]          w_row_hot;
    logic [W-1:0]          w_captured_nxt;
    logic [N_DUT-1:0]      w_mismatch;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_cnt_inc   = 1'b0;
        w_sample    = 1'b0;
        w_check     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (r_cnt == CNT_LAST) w_state_nxt = ST_SAMPLE;
                else                   w_cnt_inc   = 1'b1;
            end
            ST_SAMPLE: begin
                w_sample    = 1'b1;
                w_state_nxt = (r_row == ROW_LAST) ? ST_CHECK : ST_SETTLE;
            end
            ST_CHECK: begin
                w_check     = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_row_hot        = '0;
        w_row_hot[r_row] = 1'b1;
    end

    // Each DUT's Y lands in its own slice at the current row position.
    for (genvar g = 0; g < N_DUT; g++) begin : g_cap
        localparam int unsigned LO = table_slice(g, R);
        assign w_captured_nxt[LO +: R] = (r_captured[LO +: R] & ~w_row_hot)
                                       | ({R{dut_out[g]}} & w_row_hot);
    end

    tt_compare #(
        .N_IN  (N_IN),
        .N_DUT (N_DUT)
    ) u_compare (
        .i_captured (r_captured),
        .i_expected (r_exp),
        .o_mismatch (w_mismatch)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_row      <= '0;
            r_cnt      <= '0;
            r_exp      <= '0;
            r_dut_in   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_captured <= '0;
            r_mismatch <= '0;
            r_pass     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_check;
            if (w_accept) begin
                r_exp      <= expected;
                r_captured <= '0;
                r_mismatch <= '0;
                r_pass     <= 1'b0;
                r_row      <= '0;
                r_cnt      <= '0;
                r_dut_in   <= '0;
                r_busy     <= 1'b1;
            end
            if (w_cnt_inc) r_cnt <= r_cnt + TT_CNT_W'(1);
            if (w_sample) begin
                r_captured <= w_captured_nxt;
                if (r_row != ROW_LAST) begin
                    r_row    <= r_row + N_IN'(1);
                    r_dut_in <= r_row + N_IN'(1);
                    r_cnt    <= '0;
                end else begin
                    r_dut_in <= '0;
                end
            end
            if (w_check) begin
                r_mismatch <= w_mismatch;
                r_pass     <= ~|w_mismatch;
                r_busy     <= 1'b0;
            end
        end
    end

    assign dut_in   = r_dut_in;
    assign busy     = r_busy;
    assign done     = r_done;
    assign captured = r_captured;
    assign mismatch = r_mismatch;
    assign pass     = r_pass;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomized bench for truth_table_sweeper with behavioural DUT and result models.
module tb_truth_table_sweeper;

    localparam int unsigned R     = 8;
    localparam int unsigned ND    = 6;
    localparam int unsigned W     = ND * R;
    localparam int          LAT_A = R * (1 + 1) + 1;
    localparam int          LAT_B = R * (3 + 1) + 1;
    localparam logic [7:0]  MAJ   = 8'hE8;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic          start_a, busy_a, done_a, pass_a;
    logic [W-1:0]  exp_a, cap_a;
    logic [2:0]    dut_in_a;
    logic [ND-1:0] dut_out_a, mm_a;

    logic          start_b, busy_b, done_b, pass_b;
    logic [W-1:0]  exp_b, cap_b;
    logic [2:0]    dut_in_b;
    logic [ND-1:0] dut_out_b, mm_b;

    logic [ND-1:0][R-1:0] tbl_a, tbl_b;
    logic                 delayed_a;
    logic [ND-1:0]        comb_a, comb_b, pa1, pa2, pb1, pb2;

    int n_checks = 0;
    int n_pass   = 0;

    truth_table_sweeper #(.N_IN(3), .N_DUT(ND), .SETTLE(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .expected(exp_a),
        .dut_in(dut_in_a), .dut_out(dut_out_a), .busy(busy_a), .done(done_a),
        .captured(cap_a), .mismatch(mm_a), .pass(pass_a)
    );

    truth_table_sweeper #(.N_IN(3), .N_DUT(ND), .SETTLE(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .expected(exp_b),
        .dut_in(dut_in_b), .dut_out(dut_out_b), .busy(busy_b), .done(done_b),
        .captured(cap_b), .mismatch(mm_b), .pass(pass_b)
    );

    // Behavioural lab DUTs: table lookup, optionally behind a 2-cycle delay.
    always_comb begin
        for (int d = 0; d < ND; d++) begin
            comb_a[d] = tbl_a[d][dut_in_a];
            comb_b[d] = tbl_b[d][dut_in_b];
        end
    end

    always @(posedge clk) begin
        pa1 <= comb_a;
        pa2 <= pa1;
        pb1 <= comb_b;
        pb2 <= pb1;
    end

    assign dut_out_a = delayed_a ? pa2 : comb_a;
    assign dut_out_b = pb2;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, got, want);
    endtask

    function automatic logic [W-1:0] rand_w();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[W-1:0];
    endfunction

    // With a lagging DUT and one settle cycle, row r sees the answer for row r-1.
    function automatic logic [W-1:0] ref_capture(input logic [ND-1:0][R-1:0] tbl, input bit lag);
        logic [W-1:0] c;
        for (int d = 0; d < ND; d++)
            for (int r = 0; r < R; r++)
                c[d*R + r] = tbl[d][(lag && r > 0) ? r - 1 : r];
        return c;
    endfunction

    function automatic logic [ND-1:0] ref_mismatch(input logic [W-1:0] c, input logic [W-1:0] e);
        logic [ND-1:0] m;
        for (int d = 0; d < ND; d++) m[d] = (c[d*R +: R] != e[d*R +: R]);
        return m;
    endfunction

    task automatic run_a(input logic [W-1:0] e, input int poke_at, input bit hold, input bit chg);
        logic [W-1:0]  cref;
        logic [ND-1:0] mref;
        int k, dk, k2;
        cref = ref_capture(tbl_a, delayed_a);
        mref = ref_mismatch(cref, e);
        exp_a   = e;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = hold;
        check("busy_on_accept", busy_a, 1'b1);
        check("clear_on_accept", {cap_a, mm_a, pass_a}, '0);
        k  = 0;
        dk = 0;
        while (dk == 0 && k < 4 * LAT_A) begin
            if (k < 2 * R) begin
                check("dut_in", dut_in_a, k / 2);
                check("busy_sweep", busy_a, 1'b1);
            end
            @(posedge clk); #1;
            k++;
            start_a = hold || (k == poke_at);
            if (chg && k == 8) exp_a = ~e;
            if (done_a) dk = k;
        end
        check("done_latency", dk, LAT_A);
        check("busy_at_done", busy_a, 1'b0);
        check("dut_in_at_done", dut_in_a, 0);
        check("captured", cap_a, cref);
        check("mismatch", mm_a, mref);
        check("pass", pass_a, mref == '0);
        if (hold) begin
            k2 = 0;
            dk = 0;
            while (dk == 0 && k2 < 4 * LAT_A) begin
                @(posedge clk); #1;
                k2++;
                if (done_a) dk = k2;
            end
            start_a = 1'b0;
            check("restart_latency", dk, LAT_A + 1);
            check("restart_captured", cap_a, cref);
            check("restart_mismatch", mm_a, mref);
        end
        @(posedge clk); #1;
        check("done_one_cycle", done_a, 1'b0);
        check("no_restart", busy_a, 1'b0);
        check("captured_hold", cap_a, cref);
        check("pass_hold", pass_a, mref == '0);
    endtask

    task automatic run_b(input logic [W-1:0] e);
        logic [W-1:0]  cref;
        logic [ND-1:0] mref;
        int k, dk;
        cref = ref_capture(tbl_b, 1'b0);
        mref = ref_mismatch(cref, e);
        exp_b   = e;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        k  = 0;
        dk = 0;
        while (dk == 0 && k < 4 * LAT_B) begin
            @(posedge clk); #1;
            k++;
            if (done_b) dk = k;
        end
        check("b_done_latency", dk, LAT_B);
        check("b_captured", cap_b, cref);
        check("b_mismatch", mm_b, mref);
        check("b_pass", pass_b, 1'b1);
    endtask

    initial begin
        logic [W-1:0] e;
        rst_n     = 1'b0;
        start_a   = 1'b0;
        start_b   = 1'b0;
        exp_a     = '0;
        exp_b     = '0;
        delayed_a = 1'b0;
        for (int d = 0; d < ND; d++) begin
            tbl_a[d] = MAJ;
            tbl_b[d] = MAJ;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {busy_a, done_a, dut_in_a, cap_a, mm_a, pass_a}, '0);
        check("rst_outputs_b", {busy_b, done_b, dut_in_b, pass_b}, '0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("idle_busy", busy_a, 1'b0);
            check("idle_dut_in", dut_in_a, 0);
        end

        run_a({ND{MAJ}}, 0, 1'b0, 1'b0);

        tbl_a[3] = '0;
        run_a({ND{MAJ}}, 0, 1'b0, 1'b0);
        check("stuck_dut3_mismatch", mm_a, 6'b001000);

        for (int i = 0; i < 6; i++) begin
            tbl_a = rand_w();
            e = tbl_a;
            for (int d = 0; d < ND; d++)
                if ($urandom_range(0, 2) == 0) e[d*R + $urandom_range(0, R - 1)] ^= 1'b1;
            run_a(e, 0, 1'b0, 1'b0);
        end

        tbl_a = rand_w();
        run_a(tbl_a, 5, 1'b0, 1'b0);
        run_a(rand_w(), 0, 1'b1, 1'b0);
        run_a(tbl_a, 0, 1'b0, 1'b1);

        for (int d = 0; d < ND; d++) tbl_a[d] = MAJ;
        delayed_a = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        run_a({ND{MAJ}}, 0, 1'b0, 1'b0);
        check("lag_mismatch_nonzero", mm_a != '0, 1'b1);
        delayed_a = 1'b0;

        run_b({ND{MAJ}});

        exp_a   = {ND{MAJ}};
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("row4_before_reset", dut_in_a, 4);
        check("partial_capture", cap_a != '0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_clear", {busy_a, done_a, dut_in_a, cap_a, mm_a, pass_a}, '0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("no_done_in_reset", done_a, 1'b0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("no_done_after_reset", {done_a, busy_a}, '0);
        end
        run_a({ND{MAJ}}, 0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
